// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - types, constants and helpers shared by count_monitor
//
// Contents:
//   state_t     : tracking FSM states, encoded from count_monitor_defs.vh
//   step_t      : classification of one sample against the previous one
//   RUN_W       : width of the consecutive-step run counter (covers SYNC_LEN 1..15)
//   run_reached : true when an incremented run count has hit the lock length

package count_monitor_pkg;

`include "count_monitor_defs.vh"

    typedef enum logic [1:0] {
        ST_INIT  = `CM_ST_INIT,
        ST_SYNC  = `CM_ST_SYNC,
        ST_TRACK = `CM_ST_TRACK
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_INC  = 2'd1,
        STEP_JUMP = 2'd2
    } step_t;

    localparam int RUN_W = 4;

    function automatic logic run_reached(input logic [RUN_W-1:0] run_inc,
                                         input int              sync_len);
        return run_inc == RUN_W'(sync_len);
    endfunction

endpackage

// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - signal bundle between the count source/host and count_monitor
//
// Signals:
//   q        : sampled count value from the upstream ripple counter
//   clear    : synchronous clear of statistics and lock (active high)
//   locked   : monitor is tracking a valid +1 sequence
//   wrap     : one-cycle pulse on a max->0 step while locked
//   seq_err  : one-cycle pulse on a sequence violation while locked
//   err_cnt  : saturating count of seq_err pulses
//   wrap_cnt : free-running count of wrap pulses
// Modports:
//   master : drives q/clear, observes status
//   slave  : the monitor itself

interface count_monitor_if #(
    parameter int WIDTH  = 4,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  q;
    logic              clear;
    logic              locked;
    logic              wrap;
    logic              seq_err;
    logic [ERR_W-1:0]  err_cnt;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output q,
        output clear,
        input  locked,
        input  wrap,
        input  seq_err,
        input  err_cnt,
        input  wrap_cnt
    );

    modport slave (
        input  q,
        input  clear,
        output locked,
        output wrap,
        output seq_err,
        output err_cnt,
        output wrap_cnt
    );
endinterface

// File: rtl/count_monitor_defs.vh
// rtl/count_monitor_defs.vh - shared FSM state encodings for count_monitor
`ifndef COUNT_MONITOR_DEFS_VH
`define COUNT_MONITOR_DEFS_VH

`define CM_ST_INIT  2'd0
`define CM_ST_SYNC  2'd1
`define CM_ST_TRACK 2'd2

`endif

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones
//
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset, clears value
//   clr   : synchronous clear, wins over inc
//   inc   : count one event
//   value : current count, holds at 2^WIDTH-1

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !(&value)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - checks that an upstream counter advances by +1 per clock
//
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : count_monitor_if slave (q, clear in; locked, wrap, seq_err,
//           err_cnt, wrap_cnt out)
//
// q is registered into q_s and compared against the previous sample q_p.
// The classification of a sample is registered into the outputs on the
// following edge, so a value on q shows up on the pulses two edges later.
// No output depends combinationally on q or clear.

module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SYNC_LEN = 2,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    count_monitor_if.slave bus
);

    logic [WIDTH-1:0]  q_s;
    logic [WIDTH-1:0]  q_p;
    logic [WIDTH-1:0]  q_p_inc;
    logic              s_valid;

    state_t            state;
    state_t            state_nxt;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_nxt;
    logic [RUN_W-1:0]  run_inc;
    step_t             step;

    logic              wrap_nxt;
    logic              err_nxt;
    logic              wrap_r;
    logic              seq_err_r;
    logic [WRAP_W-1:0] wrap_cnt_r;
    logic [ERR_W-1:0]  err_val;

    // Sample pipeline. s_valid marks that q_s holds a real sample, so INIT
    // waits one edge before the first q_s/q_p comparison becomes meaningful.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_s     <= '0;
            q_p     <= '0;
            s_valid <= 1'b0;
        end else begin
            q_s     <= bus.q;
            q_p     <= q_s;
            s_valid <= 1'b1;
        end
    end

    assign q_p_inc = q_p + WIDTH'(1);
    assign run_inc = run + RUN_W'(1);

    always_comb begin
        step = STEP_JUMP;
        if (q_s == q_p_inc) begin
            step = STEP_INC;
        end else if (q_s == q_p) begin
            step = STEP_HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
            run   <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bus.clear) begin
            // clear overrides whatever the current sample would have caused
            state_nxt = ST_INIT;
            run_nxt   = '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (s_valid) begin
                        state_nxt = ST_SYNC;
                        run_nxt   = '0;
                    end
                end
                ST_SYNC: begin
                    case (step)
                        STEP_INC: begin
                            if (run_reached(run_inc, SYNC_LEN)) begin
                                state_nxt = ST_TRACK;
                                run_nxt   = '0;
                            end else begin
                                run_nxt = run_inc;
                            end
                        end
                        STEP_HOLD: begin
                            run_nxt = run;
                        end
                        default: begin
                            run_nxt = '0;
                        end
                    endcase
                end
                ST_TRACK: begin
                    case (step)
                        STEP_INC: begin
                            wrap_nxt = &q_p;
                        end
                        STEP_HOLD: begin
                            wrap_nxt = 1'b0;
                        end
                        default: begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_SYNC;
                            run_nxt   = '0;
                        end
                    endcase
                end
                default: begin
                    state_nxt = ST_INIT;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_r     <= 1'b0;
            seq_err_r  <= 1'b0;
            wrap_cnt_r <= '0;
        end else begin
            wrap_r    <= wrap_nxt;
            seq_err_r <= err_nxt;
            if (bus.clear) begin
                wrap_cnt_r <= '0;
            end else if (wrap_nxt) begin
                wrap_cnt_r <= wrap_cnt_r + WRAP_W'(1);
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.clear),
        .inc   (err_nxt),
        .value (err_val)
    );

    assign bus.locked   = (state == ST_TRACK);
    assign bus.wrap     = wrap_r;
    assign bus.seq_err  = seq_err_r;
    assign bus.err_cnt  = err_val;
    assign bus.wrap_cnt = wrap_cnt_r;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - scoreboard bench for count_monitor
module tb_count_monitor;

    typedef struct packed {
        int          when;
        logic        locked;
        logic        wrap;
        logic        seq_err;
        logic [7:0]  err_cnt;
        logic [7:0]  wrap_cnt;
        logic [63:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   ecnt = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    count_monitor_if #(.WIDTH(4), .ERR_W(8), .WRAP_W(8)) bus ();

    count_monitor #(
        .WIDTH    (4),
        .SYNC_LEN (2),
        .ERR_W    (8),
        .WRAP_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].when <= ecnt) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.when != ecnt ||
                bus.locked !== mon_e.locked || bus.wrap !== mon_e.wrap ||
                bus.seq_err !== mon_e.seq_err || bus.err_cnt !== mon_e.err_cnt ||
                bus.wrap_cnt !== mon_e.wrap_cnt) begin
                errors++;
                $display("FAIL %0s @%0d (due %0d): got locked=%b wrap=%b seq_err=%b err_cnt=%0d wrap_cnt=%0d, expected locked=%b wrap=%b seq_err=%b err_cnt=%0d wrap_cnt=%0d",
                         mon_e.tag, ecnt, mon_e.when, bus.locked, bus.wrap, bus.seq_err,
                         bus.err_cnt, bus.wrap_cnt, mon_e.locked, mon_e.wrap,
                         mon_e.seq_err, mon_e.err_cnt, mon_e.wrap_cnt);
            end
        end
    end

    task automatic push_exp(input int when, input logic el, input logic ew, input logic es,
                            input logic [7:0] ee, input logic [7:0] ewc, input logic [63:0] tag);
        exp_t e;
        e.when     = when;
        e.locked   = el;
        e.wrap     = ew;
        e.seq_err  = es;
        e.err_cnt  = ee;
        e.wrap_cnt = ewc;
        e.tag      = tag;
        sb.push_back(e);
    endtask

    // Drive one sample; its classification is visible two edges later.
    task automatic apply(input logic [3:0] v, input logic clr, input logic el,
                         input logic ew, input logic es, input logic [7:0] ee,
                         input logic [7:0] ewc, input logic [63:0] tag);
        @(negedge clk);
        bus.q     = v;
        bus.clear = clr;
        push_exp(ecnt + 2, el, ew, es, ee, ewc, tag);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ee;
        reset     = 1'b0;
        bus.q     = 4'd0;
        bus.clear = 1'b0;

        @(negedge clk);
        push_exp(ecnt + 1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "rst");
        @(negedge clk);
        reset = 1'b1;

        // count up from 0; lock after two steps, wrap once on 15->0
        for (int v = 1; v < 16; v++) apply(4'(v), 1'b0, (v >= 2), 1'b0, 1'b0, 8'd0, 8'd0, "count");
        apply(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1, "wrap");
        apply(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, "postwrap");
        for (int v = 2; v < 7; v++) apply(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1, "pre_jmp");

        // 6 -> 9 jump, relock after 10, 11
        apply(4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd1, "jump");
        apply(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, "resync");
        apply(4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, "relock");
        for (int v = 12; v < 16; v++) apply(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, "to_max");
        apply(4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd2, "wrap2");
        for (int v = 1; v < 8; v++) apply(4'(v), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, "to_7");

        // hold at 7
        repeat (10) apply(4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, "hold");

        // 300 jump/relock rounds; err_cnt sticks at 255
        for (int i = 1; i <= 300; i++) begin
            ee = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            apply(4'd12, 1'b0, 1'b0, 1'b0, 1'b1, ee, 8'd2, "sat_jmp");
            apply(4'd13, 1'b0, 1'b0, 1'b0, 1'b0, ee, 8'd2, "sat_sync");
            apply(4'd14, 1'b0, 1'b1, 1'b0, 1'b0, ee, 8'd2, "sat_lock");
        end

        // clear lands on the same edge that classifies the 14 -> 3 jump
        apply(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "clr_jmp");
        apply(4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "clr_init");
        apply(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "clr_sync");
        apply(4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "clr_lock");
        apply(4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "clr_trk");
        wait_drain();

        // asynchronous reset between edges while tracking
        @(posedge clk);
        #1 reset = 1'b0;
        push_exp(ecnt, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "async_rs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus.q = 4'd9;
        apply(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, "rs_sync");
        apply(4'd11, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "rs_lock");
        apply(4'd12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, "rs_trk");
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
